// File: rtl/shift_left_arb_pkg.sv
// Shared constants, types and helpers for the shift-left arbiter slice.
package shift_left_arb_pkg;

    localparam int unsigned DEF_WIDTH   = 8;
    localparam int unsigned DEF_SHIFT_W = $clog2(DEF_WIDTH + 1);
    localparam int unsigned DEF_NUM_REQ = 4;

    // Requester index width, never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [DEF_WIDTH-1:0]   data;
        logic [DEF_SHIFT_W-1:0] shift;
    } shift_req_t;

endpackage

// File: rtl/shift_left_arbiter_rr.sv
// Combinational round-robin picker: first valid at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  i_valid,
    input  logic [ID_WIDTH-1:0] i_ptr,
    input  logic                i_enable,
    output logic [NUM_REQ-1:0]  o_grant_c,
    output logic [ID_WIDTH-1:0] o_idx_c,
    output logic                o_any_c
);

    int unsigned w_best;
    int unsigned w_dist;

    // Smallest wrap distance from the pointer wins.
    always_comb begin
        o_idx_c = '0;
        o_any_c = 1'b0;
        w_best  = NUM_REQ;
        w_dist  = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_dist = (i + NUM_REQ - 32'(i_ptr)) % NUM_REQ;
            if (i_valid[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                o_idx_c = ID_WIDTH'(i);
                o_any_c = 1'b1;
            end
        end
    end

    always_comb begin
        o_grant_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            o_grant_c[i] = i_enable && o_any_c && (32'(o_idx_c) == i);
        end
    end

endmodule

// File: rtl/shift_left_arbiter_shl.sv
// Truncating left shift with a flag for any set bit pushed past the MSB.
module shift_left #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned SHIFT_VAL_WIDTH = 4
) (
    input  logic [WIDTH-1:0]           i_data,
    input  logic [SHIFT_VAL_WIDTH-1:0] i_shift,
    output logic [WIDTH-1:0]           o_data_c,
    output logic                       o_overflow_c
);

    localparam logic [SHIFT_VAL_WIDTH-1:0] W_CODE = SHIFT_VAL_WIDTH'(WIDTH);

    logic                       w_in_range;
    logic [SHIFT_VAL_WIDTH-1:0] w_rshift;

    assign w_in_range = (i_shift < W_CODE);
    // A zero shift gives a right shift of WIDTH, which clears the flag naturally.
    assign w_rshift   = W_CODE - i_shift;

    assign o_data_c     = w_in_range ? (i_data << i_shift) : '0;
    assign o_overflow_c = w_in_range ? (|(i_data >> w_rshift)) : (|i_data);

endmodule

// File: rtl/shift_left_arbiter.sv
// Round-robin sharing of one left-shift datapath with a single registered result slot.
module shift_left_arbiter
    import shift_left_arb_pkg::*;
#(
    parameter int unsigned WIDTH           = DEF_WIDTH,
    parameter int unsigned SHIFT_VAL_WIDTH = $clog2(WIDTH + 1),
    parameter int unsigned NUM_REQ         = DEF_NUM_REQ,
    parameter int unsigned ID_WIDTH        = id_width(NUM_REQ)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]           req_in,
    input  logic [NUM_REQ*SHIFT_VAL_WIDTH-1:0] req_shift,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH-1:0]                   out_data,
    output logic [ID_WIDTH-1:0]                out_id,
    output logic                               out_overflow
);

    logic                       r_out_valid;
    logic [WIDTH-1:0]           r_out_data;
    logic [ID_WIDTH-1:0]        r_out_id;
    logic                       r_out_overflow;
    logic [ID_WIDTH-1:0]        r_ptr;

    logic                       w_accept;
    logic                       w_enable;
    logic [NUM_REQ-1:0]         w_grant;
    logic [ID_WIDTH-1:0]        w_idx;
    logic                       w_any;
    logic                       w_take;
    logic [WIDTH-1:0]           w_sel_data;
    logic [SHIFT_VAL_WIDTH-1:0] w_sel_shift;
    logic [WIDTH-1:0]           w_shl_data;
    logic                       w_shl_ovf;
    logic [ID_WIDTH-1:0]        w_ptr_next;

    // Slot is free or drains this cycle; reset blocks any new acceptance.
    assign w_accept = !r_out_valid || out_ready;
    assign w_enable = w_accept && !reset;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr (
        .i_valid   (req_valid),
        .i_ptr     (r_ptr),
        .i_enable  (w_enable),
        .o_grant_c (w_grant),
        .o_idx_c   (w_idx),
        .o_any_c   (w_any)
    );

    assign req_ready = w_grant;
    assign w_take    = |w_grant;

    always_comb begin
        w_sel_data  = '0;
        w_sel_shift = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (32'(w_idx) == i) begin
                w_sel_data  = req_in[i*WIDTH +: WIDTH];
                w_sel_shift = req_shift[i*SHIFT_VAL_WIDTH +: SHIFT_VAL_WIDTH];
            end
        end
    end

    shift_left #(
        .WIDTH           (WIDTH),
        .SHIFT_VAL_WIDTH (SHIFT_VAL_WIDTH)
    ) u_shl (
        .i_data       (w_sel_data),
        .i_shift      (w_sel_shift),
        .o_data_c     (w_shl_data),
        .o_overflow_c (w_shl_ovf)
    );

    assign w_ptr_next = (32'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + ID_WIDTH'(1);

    // Result slot and pointer; a drain without reload keeps the old payload.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_id       <= '0;
            r_out_overflow <= 1'b0;
            r_ptr          <= '0;
        end else if (w_take) begin
            r_out_valid    <= 1'b1;
            r_out_data     <= w_shl_data;
            r_out_id       <= w_idx;
            r_out_overflow <= w_shl_ovf;
            r_ptr          <= w_ptr_next;
        end else if (out_ready) begin
            r_out_valid    <= 1'b0;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_id       = r_out_id;
    assign out_overflow = r_out_overflow;

    logic w_unused;
    assign w_unused = w_any;

endmodule

// File: tb/tb_shift_left_arbiter.sv
// Randomized and directed checks of shift_left_arbiter against a behavioural model.
module tb_shift_left_arbiter;

    localparam int unsigned W   = 8;
    localparam int unsigned SW  = 4;
    localparam int unsigned N   = 4;
    localparam int unsigned IDW = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_in;
    logic [N*SW-1:0]  req_shift;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [IDW-1:0]   out_id;
    logic             out_overflow;

    shift_left_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_in       (req_in),
        .req_shift    (req_shift),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_id       (out_id),
        .out_overflow (out_overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        int id;
        int data;
        int ovf;
    } exp_t;

    int   n_checks = 0;
    int   n_errors = 0;
    bit   rv [N];
    int   rin[N];
    int   rsh[N];
    int   waits[N];
    bit   random_mode = 1'b0;
    exp_t sb[$];
    int   n_acc = 0;
    int   n_del = 0;

    // Model of the result slot and the round-robin pointer.
    bit m_valid = 1'b0;
    int m_data  = 0;
    int m_id    = 0;
    int m_ovf   = 0;
    int m_ptr   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Left shift as multiplication by a power of two; overflow means the product no longer fits.
    task automatic ref_shift(input int in, input int sh, output int data, output int ovf);
        longint p;
        p    = longint'(in) * (longint'(1) << sh);
        data = int'(p % 256);
        ovf  = (p >= 256) ? 1 : 0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = rv[i];
            req_in[i*W +: W]       = W'(rin[i]);
            req_shift[i*SW +: SW]  = SW'(rsh[i]);
        end
    endtask

    task automatic new_payload(input int i);
        rin[i] = int'($urandom_range(255, 0));
        rsh[i] = int'($urandom_range(15, 0));
    endtask

    // One clock: check at the falling edge, advance model, then update requesters.
    task automatic cycle();
        logic [N-1:0] er;
        int   win;
        int   d;
        int   o;
        exp_t e;
        @(negedge clock);
        er  = '0;
        win = -1;
        if (!reset && (!m_valid || out_ready)) begin
            for (int k = 0; k < N; k++) begin
                if (win < 0 && rv[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
        end
        if (win >= 0) er[win] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), m_data);
        chk("out_id", 32'(out_id), m_id);
        chk("out_overflow", 32'(out_overflow), m_ovf);

        if (reset) begin
            n_acc -= sb.size();
            sb.delete();
            for (int i = 0; i < N; i++) waits[i] = 0;
        end else begin
            if (m_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 32'(0), 32'(1));
                end else begin
                    e = sb.pop_front();
                    chk("sb_id", 32'(out_id), e.id);
                    chk("sb_data", 32'(out_data), e.data);
                    n_del++;
                end
            end
            if (win >= 0) begin
                chk("fair_wait", 32'(waits[win] < N), 32'(1));
                waits[win] = 0;
                for (int i = 0; i < N; i++) if (i != win && rv[i]) waits[i]++;
            end
        end

        if (reset) begin
            m_valid = 1'b0; m_data = 0; m_id = 0; m_ovf = 0; m_ptr = 0;
        end else if (win >= 0) begin
            ref_shift(rin[win], rsh[win], d, o);
            m_valid = 1'b1; m_data = d; m_id = win; m_ovf = o;
            m_ptr   = (win + 1) % N;
            e.id = win; e.data = d; e.ovf = o;
            sb.push_back(e);
            n_acc++;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end

        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            if (i == win) begin
                new_payload(i);
                if (random_mode) rv[i] = ($urandom_range(1, 0) == 1);
            end else if (random_mode && !rv[i] && $urandom_range(9, 0) < 4) begin
                rv[i] = 1'b1;
                new_payload(i);
            end
        end
        drive();
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) rv[i] = 1'b0;
        drive();
    endtask

    task automatic single(input int id, input int in, input int sh, input int ed, input int eo);
        clear_reqs();
        rv[id] = 1'b1; rin[id] = in; rsh[id] = sh;
        out_ready = 1'b1;
        drive();
        cycle();
        clear_reqs();
        chk("shl_data", 32'(out_data), ed);
        chk("shl_ovf", 32'(out_overflow), eo);
        chk("shl_id", 32'(out_id), id);
    endtask

    initial begin
        int sd;
        int sid;
        reset     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            rv[i] = 1'b1;
            waits[i] = 0;
            new_payload(i);
        end
        drive();

        // Reset held with every requester asking.
        cycle();
        cycle();
        reset = 1'b0;

        // Round robin under continuous readiness.
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rr_valid", 32'(out_valid), 32'(1));
            chk("rr_id", 32'(out_id), k % N);
        end

        // Backpressure holds the slot and blocks grants.
        out_ready = 1'b0;
        sd  = int'(out_data);
        sid = int'(out_id);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_ready", 32'(req_ready), 32'(0));
            chk("bp_data", 32'(out_data), sd);
            chk("bp_id", 32'(out_id), sid);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_resume_id", 32'(out_id), (sid + 1) % N);

        // Shift arithmetic corners.
        single(2, 8'h81, 1, 8'h02, 1);
        single(0, 8'h0F, 4, 8'hF0, 0);
        single(1, 8'h01, 8, 8'h00, 1);
        single(3, 8'h00, 15, 8'h00, 0);
        single(2, 8'hA5, 0, 8'hA5, 0);

        // Sparse requests and pointer wrap.
        clear_reqs();
        cycle();
        rv[3] = 1'b1; new_payload(3); drive();
        cycle();
        clear_reqs();
        chk("sparse_3", 32'(out_id), 32'(3));
        rv[0] = 1'b1; rv[2] = 1'b1; drive();
        cycle();
        clear_reqs();
        chk("wrap_0", 32'(out_id), 32'(0));
        rv[1] = 1'b1; drive();
        cycle();
        clear_reqs();
        chk("sparse_1", 32'(out_id), 32'(1));

        // Random traffic with one mid-run reset.
        random_mode = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            out_ready = ($urandom_range(9, 0) < 7);
            reset     = (c == 1500);
            cycle();
        end
        reset       = 1'b0;
        random_mode = 1'b0;
        out_ready   = 1'b1;
        clear_reqs();
        cycle();
        cycle();
        chk("no_loss", 32'(n_del), 32'(n_acc));
        chk("sb_drained", 32'(sb.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
